// File: rtl/ship_fire_ctrl.sv
// Ship rotation and projectile-launch controller: edge-detected rotate/fire buttons,
// four firing sequences with cooldown, and a shot FIFO drained over valid/ready.
module ship_fire_ctrl #(
  parameter int ANGLE_W      = 4,
  parameter int ROT_STEP     = 1,
  parameter int BURST_LEN    = 3,
  parameter int BURST_GAP    = 4,
  parameter int RAPID_PERIOD = 8,
  parameter int COOLDOWN     = 8,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_cw,
  input  logic                           btn_ccw,
  input  logic                           btn_fire,
  input  logic [1:0]                     mode,
  output logic [ANGLE_W-1:0]             angle_out,
  output logic                           shot_valid,
  output logic [ANGLE_W-1:0]             shot_angle,
  output logic [1:0]                     shot_mode,
  input  logic                           shot_ready,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           dropped
);
  localparam int PW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = PW + 1;
  localparam int TMAX = (BURST_GAP > RAPID_PERIOD) ? BURST_GAP : RAPID_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(BURST_LEN + 3);
  localparam int CDW  = $clog2(COOLDOWN + 2);

  localparam logic [TW-1:0]      GAP_L  = TW'(BURST_GAP);
  localparam logic [TW-1:0]      PER_L  = TW'(RAPID_PERIOD);
  localparam logic [CDW-1:0]     COOL_L = CDW'(COOLDOWN);
  localparam logic [SW-1:0]      LEN_L  = SW'(BURST_LEN);
  localparam logic [ANGLE_W-1:0] STEP_L = ANGLE_W'(ROT_STEP);
  localparam logic [ANGLE_W-1:0] ONE_A  = ANGLE_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_BURST, S_SPREAD, S_RAPID, S_COOL} state_t;

  state_t                 r_state, w_state_next;
  logic                   r_cw_prev, r_ccw_prev, r_fire_prev;
  logic [ANGLE_W-1:0]     r_angle, w_angle_next;
  logic [ANGLE_W-1:0]     r_cap_angle, w_cap_angle_next;
  logic [TW-1:0]          r_tmr, w_tmr_next;
  logic [SW-1:0]          r_shots, w_shots_next;
  logic [CDW-1:0]         r_cool, w_cool_next;
  logic [ANGLE_W+1:0]     r_mem [QUEUE_DEPTH];
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic                   r_dropped;

  logic                   w_cw_press, w_ccw_press, w_fire_press;
  logic                   w_push, w_done, w_pop, w_full, w_wr, w_drop;
  logic [ANGLE_W-1:0]     w_push_angle;
  logic [1:0]             w_push_mode;

  assign w_cw_press   = btn_cw & ~r_cw_prev;
  assign w_ccw_press  = btn_ccw & ~r_ccw_prev;
  assign w_fire_press = btn_fire & ~r_fire_prev;

  always_comb begin
    w_angle_next = r_angle;
    if (w_cw_press && !w_ccw_press)
      w_angle_next = r_angle + STEP_L;
    else if (w_ccw_press && !w_cw_press)
      w_angle_next = r_angle - STEP_L;
  end

  always_comb begin
    w_state_next     = r_state;
    w_tmr_next       = r_tmr;
    w_shots_next     = r_shots;
    w_cool_next      = r_cool;
    w_cap_angle_next = r_cap_angle;
    w_push           = 1'b0;
    w_push_angle     = r_angle;
    w_push_mode      = 2'b00;
    w_done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire_press) begin
          // First shot of every sequence leaves on the triggering edge.
          w_push           = 1'b1;
          w_push_mode      = mode;
          w_cap_angle_next = r_angle;
          case (mode)
            2'b00: w_done = 1'b1;
            2'b01: begin
              if (BURST_LEN <= 1) begin
                w_done = 1'b1;
              end else begin
                w_state_next = S_BURST;
                w_tmr_next   = GAP_L;
                w_shots_next = LEN_L - SW'(1);
              end
            end
            2'b10: begin
              w_push_angle = r_angle - ONE_A;
              w_state_next = S_SPREAD;
              w_shots_next = SW'(1);
            end
            default: begin
              w_state_next = S_RAPID;
              w_tmr_next   = PER_L;
            end
          endcase
        end
      end
      S_BURST: begin
        w_push_mode  = 2'b01;
        w_push_angle = r_cap_angle;
        if (r_tmr == TW'(1)) begin
          w_push       = 1'b1;
          w_tmr_next   = GAP_L;
          w_shots_next = r_shots - SW'(1);
          w_done       = (r_shots == SW'(1));
        end else begin
          w_tmr_next = r_tmr - TW'(1);
        end
      end
      S_SPREAD: begin
        w_push       = 1'b1;
        w_push_mode  = 2'b10;
        w_push_angle = r_cap_angle + ((r_shots == SW'(2)) ? ONE_A : '0);
        w_shots_next = r_shots + SW'(1);
        w_done       = (r_shots == SW'(2));
      end
      S_RAPID: begin
        w_push_mode = 2'b11;
        if (!btn_fire) begin
          w_done = 1'b1;
        end else if (r_tmr == TW'(1)) begin
          w_push     = 1'b1;
          w_tmr_next = PER_L;
        end else begin
          w_tmr_next = r_tmr - TW'(1);
        end
      end
      S_COOL: begin
        if (r_cool <= CDW'(1)) begin
          w_state_next = S_IDLE;
          w_cool_next  = '0;
        end else begin
          w_cool_next = r_cool - CDW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_done) begin
      if (COOLDOWN == 0) begin
        w_state_next = S_IDLE;
      end else begin
        w_state_next = S_COOL;
        w_cool_next  = COOL_L;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop  = (r_count != '0) && shot_ready;
  assign w_full = (r_count == CW'(QUEUE_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cw_prev   <= 1'b1;
      r_ccw_prev  <= 1'b1;
      r_fire_prev <= 1'b1;
      r_angle     <= '0;
      r_cap_angle <= '0;
      r_tmr       <= '0;
      r_shots     <= '0;
      r_cool      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dropped   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cw_prev   <= btn_cw;
      r_ccw_prev  <= btn_ccw;
      r_fire_prev <= btn_fire;
      r_angle     <= w_angle_next;
      r_cap_angle <= w_cap_angle_next;
      r_tmr       <= w_tmr_next;
      r_shots     <= w_shots_next;
      r_cool      <= w_cool_next;
      r_dropped   <= w_drop;
      if (w_wr)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_wr)
      r_mem[r_wptr] <= {w_push_mode, w_push_angle};
  end

  assign angle_out                 = r_angle;
  assign shot_valid                = (r_count != '0);
  assign {shot_mode, shot_angle}   = r_mem[r_rptr];
  assign busy                      = (r_state != S_IDLE);
  assign queue_count               = r_count;
  assign dropped                   = r_dropped;

endmodule

// File: tb/tb_ship_fire_ctrl.sv
// Bench for ship_fire_ctrl: directed scenarios plus a randomized run against a
// time-scheduled model of shot launches, cooldown windows and the shot queue.
module tb_ship_fire_ctrl;
  localparam int AW = 4, BL = 3, BG = 4, RP = 8, CD = 8, QD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          btn_cw = 1'b0, btn_ccw = 1'b0, btn_fire = 1'b0, shot_ready = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] angle_out, shot_angle;
  logic          shot_valid, busy, dropped;
  logic [1:0]    shot_mode;
  logic [2:0]    queue_count;

  always #5 clk = ~clk;

  ship_fire_ctrl #(
    .ANGLE_W(AW), .ROT_STEP(1), .BURST_LEN(BL), .BURST_GAP(BG),
    .RAPID_PERIOD(RP), .COOLDOWN(CD), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset(reset), .btn_cw(btn_cw), .btn_ccw(btn_ccw), .btn_fire(btn_fire),
    .mode(mode), .angle_out(angle_out), .shot_valid(shot_valid), .shot_angle(shot_angle),
    .shot_mode(shot_mode), .shot_ready(shot_ready), .busy(busy),
    .queue_count(queue_count), .dropped(dropped)
  );

  int n_vec = 0, n_err = 0;

  // Reference model: launches are scheduled as absolute edge times when a
  // sequence is accepted; free_at is the first edge a new trigger may be taken.
  typedef struct { int tm; logic [AW-1:0] a; logic [1:0] md; } ev_t;
  typedef struct { logic [AW-1:0] a; logic [1:0] md; } shot_t;
  ev_t          pend[$];
  shot_t        fq[$];
  int           t = 0, free_at = 0, rapid_start = 0;
  bit           rapid_on = 0, m_drop = 0, m_busy = 0;
  bit           m_pcw = 1, m_pccw = 1, m_pfire = 1;
  logic [AW-1:0] m_angle = '0;

  task automatic model_step();
    bit cwp, ccwp, firep, do_push, pop;
    shot_t ps;
    logic [AW-1:0] ap;
    if (!reset) begin
      fq.delete(); pend.delete();
      m_angle = '0; m_pcw = 1; m_pccw = 1; m_pfire = 1;
      free_at = t + 1; rapid_on = 0; m_drop = 0; m_busy = 0;
      t++;
      return;
    end
    cwp = btn_cw && !m_pcw; ccwp = btn_ccw && !m_pccw; firep = btn_fire && !m_pfire;
    do_push = 0; ps.a = '0; ps.md = '0;
    ap = m_angle + 4'd1;
    if (rapid_on) begin
      if (!btn_fire) begin
        rapid_on = 0; free_at = t + CD + 1;
      end else if ((t - rapid_start) % RP == 0) begin
        do_push = 1; ps.a = m_angle; ps.md = 2'd3;
      end
    end else if (firep && t >= free_at) begin
      do_push = 1; ps.a = m_angle; ps.md = mode;
      case (mode)
        2'd0: free_at = t + CD + 1;
        2'd1: begin
          for (int n = 1; n < BL; n++) pend.push_back('{t + n * BG, m_angle, 2'd1});
          free_at = t + (BL - 1) * BG + CD + 1;
        end
        2'd2: begin
          ps.a = m_angle - 4'd1;
          pend.push_back('{t + 1, m_angle, 2'd2});
          pend.push_back('{t + 2, ap, 2'd2});
          free_at = t + 2 + CD + 1;
        end
        default: begin rapid_on = 1; rapid_start = t; end
      endcase
    end
    for (int i = 0; i < pend.size(); ) begin
      if (pend[i].tm == t) begin
        do_push = 1; ps.a = pend[i].a; ps.md = pend[i].md; pend.delete(i);
      end else i++;
    end
    pop = (fq.size() > 0) && shot_ready;
    if (pop) void'(fq.pop_front());
    m_drop = 0;
    if (do_push) begin
      if (fq.size() < QD) fq.push_back(ps);
      else m_drop = 1;
    end
    if (cwp && !ccwp) m_angle = m_angle + 4'd1;
    else if (ccwp && !cwp) m_angle = m_angle - 4'd1;
    m_pcw = btn_cw; m_pccw = btn_ccw; m_pfire = btn_fire;
    m_busy = rapid_on || (t + 1 < free_at);
    t++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_cw();
    btn_cw = 1; tick(); btn_cw = 0; tick();
  endtask

  task automatic set_angle(input logic [AW-1:0] target);
    for (int i = 0; i < 16 && m_angle != target; i++) press_cw();
  endtask

  task automatic test_reset();
    reset = 0; btn_cw = 1; repeat (3) tick();
    n_vec++; if (angle_out !== 4'd0) begin n_err++; $display("FAIL rst_angle got=%0d exp=0", angle_out); end
    n_vec++; if (shot_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", shot_valid); end
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL rst_dropped got=%0b exp=0", dropped); end
    reset = 1; repeat (5) tick();
    n_vec++; if (angle_out !== 4'd0) begin n_err++; $display("FAIL held_through_reset got=%0d exp=0", angle_out); end
    btn_cw = 0; tick(); btn_cw = 1; repeat (5) tick(); btn_cw = 0; tick();
    n_vec++; if (angle_out !== 4'd1) begin n_err++; $display("FAIL cw_hold_one_press got=%0d exp=1", angle_out); end
  endtask

  task automatic test_rotation();
    repeat (15) press_cw();
    n_vec++; if (angle_out !== 4'd0) begin n_err++; $display("FAIL cw_wrap got=%0d exp=0", angle_out); end
    btn_ccw = 1; tick(); btn_ccw = 0; tick();
    n_vec++; if (angle_out !== 4'd15) begin n_err++; $display("FAIL ccw_wrap got=%0d exp=15", angle_out); end
    btn_cw = 1; btn_ccw = 1; tick(); btn_cw = 0; btn_ccw = 0; tick();
    n_vec++; if (angle_out !== 4'd15) begin n_err++; $display("FAIL cw_ccw_cancel got=%0d exp=15", angle_out); end
  endtask

  task automatic test_single();
    set_angle(4'd5); mode = 2'b00; shot_ready = 1;
    btn_fire = 1; tick();
    n_vec++; if (shot_valid !== 1'b1 || shot_angle !== 4'd5) begin n_err++; $display("FAIL single_head got=%0b/%0d exp=1/5", shot_valid, shot_angle); end
    n_vec++; if (shot_mode !== 2'b00) begin n_err++; $display("FAIL single_mode got=%0d exp=0", shot_mode); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%0b exp=1", busy); end
    $display("shot angle=%0d mode=%0d", shot_angle, shot_mode);
    btn_fire = 0; tick(); tick();
    n_vec++; if (shot_valid !== 1'b0) begin n_err++; $display("FAIL single_one_handshake got=%0b exp=0", shot_valid); end
    btn_fire = 1; tick(); btn_fire = 0;
    n_vec++; if (shot_valid !== 1'b0) begin n_err++; $display("FAIL fire_in_cool_ignored got=%0b exp=0", shot_valid); end
    repeat (4) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cool_t7_busy got=%0b exp=1", busy); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cool_t8_idle got=%0b exp=0", busy); end
    btn_fire = 1; tick(); btn_fire = 0;
    n_vec++; if (shot_valid !== 1'b1 || shot_angle !== 4'd5) begin n_err++; $display("FAIL refire_t9 got=%0b/%0d exp=1/5", shot_valid, shot_angle); end
    repeat (12) tick();
  endtask

  task automatic test_burst();
    set_angle(4'd3); shot_ready = 0; mode = 2'b01;
    btn_fire = 1; tick();
    btn_fire = 0; mode = 2'b00;
    n_vec++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL burst_k got=%0d exp=1", queue_count); end
    btn_cw = 1; tick(); btn_cw = 0; tick(); tick();
    n_vec++; if (queue_count !== 3'd1 || angle_out !== 4'd4) begin n_err++; $display("FAIL burst_k3 got=%0d/%0d exp=1/4", queue_count, angle_out); end
    tick();
    n_vec++; if (queue_count !== 3'd2) begin n_err++; $display("FAIL burst_k4 got=%0d exp=2", queue_count); end
    repeat (4) tick();
    n_vec++; if (queue_count !== 3'd3 || busy !== 1'b1) begin n_err++; $display("FAIL burst_k8 got=%0d/%0b exp=3/1", queue_count, busy); end
    shot_ready = 1;
    for (int i = 0; i < 3; i++) begin
      $display("shot angle=%0d mode=%0d", shot_angle, shot_mode);
      n_vec++; if (shot_valid !== 1'b1 || shot_angle !== 4'd3) begin n_err++; $display("FAIL burst_angle%0d got=%0b/%0d exp=1/3", i, shot_valid, shot_angle); end
      n_vec++; if (shot_mode !== 2'b01) begin n_err++; $display("FAIL burst_mode%0d got=%0d exp=1", i, shot_mode); end
      tick();
    end
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL burst_drain got=%0d exp=0", queue_count); end
    shot_ready = 0; repeat (12) tick();
  endtask

  task automatic test_spread();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 4'd15; exp_a[1] = 4'd0; exp_a[2] = 4'd1;
    set_angle(4'd0); shot_ready = 0; mode = 2'b10;
    btn_fire = 1; tick(); btn_fire = 0; tick(); tick();
    n_vec++; if (queue_count !== 3'd3) begin n_err++; $display("FAIL spread_count got=%0d exp=3", queue_count); end
    repeat (7) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL spread_busy_t7 got=%0b exp=1", busy); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL spread_idle_t8 got=%0b exp=0", busy); end
    shot_ready = 1;
    for (int i = 0; i < 3; i++) begin
      $display("shot angle=%0d mode=%0d", shot_angle, shot_mode);
      n_vec++; if (shot_angle !== exp_a[i] || shot_mode !== 2'b10) begin n_err++; $display("FAIL spread_head%0d got=%0d/%0d exp=%0d/2", i, shot_angle, shot_mode, exp_a[i]); end
      tick();
    end
    shot_ready = 0;
  endtask

  task automatic test_rapid_drop();
    shot_ready = 0; mode = 2'b11;
    btn_fire = 1; tick();
    n_vec++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL rapid_k got=%0d exp=1", queue_count); end
    repeat (7) tick();
    n_vec++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL rapid_k7 got=%0d exp=1", queue_count); end
    tick();
    n_vec++; if (queue_count !== 3'd2) begin n_err++; $display("FAIL rapid_k8 got=%0d exp=2", queue_count); end
    repeat (16) tick();
    n_vec++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL rapid_k24 got=%0d exp=4", queue_count); end
    repeat (5) tick();
    n_vec++; if (queue_count !== 3'd4 || busy !== 1'b1) begin n_err++; $display("FAIL rapid_k29 got=%0d/%0b exp=4/1", queue_count, busy); end
    btn_fire = 0; repeat (10) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rapid_cool_done got=%0b exp=0", busy); end
    mode = 2'b00; btn_fire = 1; tick();
    n_vec++; if (dropped !== 1'b1 || queue_count !== 3'd4) begin n_err++; $display("FAIL full_drop got=%0b/%0d exp=1/4", dropped, queue_count); end
    btn_fire = 0; tick();
    n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL drop_one_cycle got=%0b exp=0", dropped); end
    repeat (8) tick();
    btn_fire = 1; shot_ready = 1; tick();
    n_vec++; if (dropped !== 1'b0 || queue_count !== 3'd4) begin n_err++; $display("FAIL full_push_pop got=%0b/%0d exp=0/4", dropped, queue_count); end
    n_vec++; if (shot_mode !== 2'b11) begin n_err++; $display("FAIL full_push_pop_head got=%0d exp=3", shot_mode); end
    btn_fire = 0; repeat (20) tick();
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rapid_drain got=%0d exp=0", queue_count); end
    shot_ready = 0;
  endtask

  task automatic test_reset_mid_burst();
    mode = 2'b01; shot_ready = 0;
    btn_fire = 1; tick(); btn_fire = 0; repeat (4) tick();
    n_vec++; if (queue_count !== 3'd2) begin n_err++; $display("FAIL mid_burst_count got=%0d exp=2", queue_count); end
    reset = 0; tick();
    n_vec++; if (angle_out !== 4'd0 || shot_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_outs got=%0d/%0b exp=0/0", angle_out, shot_valid); end
    n_vec++; if (queue_count !== 3'd0 || busy !== 1'b0 || dropped !== 1'b0) begin n_err++; $display("FAIL mid_rst_state got=%0d/%0b/%0b exp=0/0/0", queue_count, busy, dropped); end
    reset = 1; repeat (12) tick();
    n_vec++; if (queue_count !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL post_rst_no_push got=%0d/%0b exp=0/0", queue_count, busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      btn_cw     = ($urandom_range(0, 3) == 0);
      btn_ccw    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) btn_fire = ~btn_fire;
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      shot_ready = ($urandom_range(0, 3) == 0);
      tick();
      n_vec++; if (angle_out !== m_angle) begin n_err++; $display("FAIL rnd_angle cyc=%0d got=%0d exp=%0d", i, angle_out, m_angle); end
      n_vec++; if (shot_valid !== (fq.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, shot_valid, fq.size() > 0); end
      if (fq.size() > 0) begin
        n_vec++; if (shot_angle !== fq[0].a || shot_mode !== fq[0].md) begin n_err++; $display("FAIL rnd_head cyc=%0d got=%0d/%0d exp=%0d/%0d", i, shot_angle, shot_mode, fq[0].a, fq[0].md); end
      end
      n_vec++; if (queue_count !== 3'(fq.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, queue_count, fq.size()); end
      n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", i, busy, m_busy); end
      n_vec++; if (dropped !== m_drop) begin n_err++; $display("FAIL rnd_dropped cyc=%0d got=%0b exp=%0b", i, dropped, m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_burst();
    test_spread();
    test_rapid_drop();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ship_fire_ctrl.md
# ship_fire_ctrl

Parametrised spaceship rotation and projectile-launch controller for the isometric shooter. It converts the rotate and fire buttons into a wrapped ship angle and a stream of shot descriptors. It supports four firing modes (single, burst, spread, rapid) with a cooldown. Shots are buffered in a FIFO and handed to the enemy controller over a valid/ready handshake, replacing the single-cycle `fire` pulse.

## Interface
Parameters:
- ANGLE_W, 4, width of ship and shot angles; angles wrap modulo 2^ANGLE_W
- ROT_STEP, 1, angle increment per rotate press
- BURST_LEN, 3, shots per burst (>=1)
- BURST_GAP, 4, cycles between burst shots (>=1)
- RAPID_PERIOD, 8, cycles between auto-repeat shots in rapid mode (>=1)
- COOLDOWN, 8, idle cycles enforced after a sequence ends (0 = none)
- QUEUE_DEPTH, 4, shot FIFO depth, power of two >=2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets the block
- btn_cw  in  1  rotate clockwise, level, pre-synchronised
- btn_ccw  in  1  rotate counter-clockwise, level, pre-synchronised
- btn_fire  in  1  fire, level, pre-synchronised
- mode  in  2  00 single, 01 burst, 10 spread, 11 rapid
- angle_out  out  ANGLE_W  current ship angle
- shot_valid  out  1  FIFO non-empty
- shot_angle  out  ANGLE_W  angle of FIFO head
- shot_mode  out  2  mode of FIFO head
- shot_ready  in  1  consumer accepts head when shot_valid && shot_ready
- busy  out  1  FSM not IDLE
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy
- dropped  out  1  one-cycle pulse, a shot was discarded because the FIFO was full

## Operation
- Edge detection: each button has a previous-sample register. A press is a sample of 1 whose previous sample was 0. Previous-sample registers reset to 1, so a button held through reset does not act.
- Rotation:
  - A cw press adds ROT_STEP; a ccw press subtracts ROT_STEP; both wrap modulo 2^ANGLE_W.
  - cw and ccw presses in the same cycle leave the angle unchanged.
  - Rotation is active in every FSM state.
- FSM states: IDLE, BURST, SPREAD, RAPID, COOL.
- A fire press is accepted only in IDLE. Fire presses in any other state are ignored, not queued.
- On an accepted press, mode and angle are captured; later mode changes do not affect the running sequence.
- Sequences:
  - Single (00): push one shot (angle, 00), then go to COOL.
  - Burst (01): push BURST_LEN shots at the captured angle, BURST_GAP cycles apart, then go to COOL.
  - Spread (10): push angle-1, angle, angle+1 (wrapped) on three consecutive cycles, then go to COOL.
  - Rapid (11): push at the current angle_out (not the captured angle) every RAPID_PERIOD cycles while btn_fire is held. If btn_fire is sampled 0 in RAPID, go to COOL; no further push occurs.
- COOL: a counter is loaded with COOLDOWN on the edge of the last push. It decrements each cycle and the FSM returns to IDLE when the counter reaches 0. With COOLDOWN=0 the FSM goes straight to IDLE.
- FIFO:
  - A push when full and not popping is discarded and pulses `dropped`; the sequence continues.
  - A push and a pop in the same cycle when full are both performed; occupancy is unchanged and there is no drop.
  - A pop when empty is ignored.
- Reset (reset==0): angle_out=0; FIFO empty; shot_valid=0; queue_count=0; dropped=0; busy=0; state IDLE; counters 0. A sequence in progress is abandoned and its queued shots are flushed.

## Timing
- A fire press sampled at edge k pushes its first shot at edge k. shot_valid is high after edge k (1-cycle latency), and busy is high from edge k.
- Burst pushes occur at edges k + n*BURST_GAP for n = 0..BURST_LEN-1.
- Spread pushes occur at edges k, k+1, k+2.
- Rapid pushes occur at edges k + n*RAPID_PERIOD while btn_fire is sampled high at each of those edges.
- If the last push is at edge t, the FSM is in IDLE after edge t+COOLDOWN. The earliest new trigger is sampled at edge t+COOLDOWN+1.
- shot_angle and shot_mode are stable while shot_valid && !shot_ready.
- A rotate press sampled at edge k updates angle_out after edge k.

## Test plan
- Reset release, hold btn_cw for 5 cycles: one press only, angle_out 0->1; 16 single cw presses wrap back to 0; simultaneous cw+ccw leaves the angle unchanged.
- Single mode at angle 5, shot_ready=1: exactly one handshake (5, 00). A second fire press during COOL is ignored; a press at t+9 (COOLDOWN=8) fires.
- Burst at angle 3, shot_ready=0: pushes at k, k+4, k+8, all angle 3, queue_count ends at 3. Rotating mid-burst does not change the angles.
- Spread at angle 0: head sequence 15, 0, 1; busy falls 8 cycles after the third push.
- Rapid held 30 cycles with shot_ready=0 and depth 4: pushes at k, k+8, k+16, k+24 fill the FIFO. Release, then with the FIFO full and shot_ready=0, fire a single shot: `dropped` pulses once and occupancy stays 4. A full FIFO with simultaneous pop and push gives no drop.
- Assert reset for one cycle mid-burst with 2 shots queued: all outputs are at reset values on the next cycle and no further pushes occur.
